// File: rtl/pfb_tap_mac.sv
// rtl/pfb_tap_mac.sv - polyphase filter bank tap multiply-accumulate stage
module pfb_tap_mac #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEF_WIDTH  = 25,
    parameter int ACC_WIDTH   = 48,
    parameter int NUM_TAPS    = 8,
    parameter int PHASE_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    input  logic                   valid_in,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [COEF_WIDTH-1:0]  coef_in,
    input  logic [PHASE_WIDTH-1:0] phase_in,
    input  logic                   last_in,
    output logic                   ready_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic [PHASE_WIDTH-1:0] phase_out,
    output logic                   ovf_out,
    output logic                   tap_err
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
    localparam int TAP_WIDTH  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [TAP_WIDTH-1:0] LAST_TAP = TAP_WIDTH'(NUM_TAPS - 1);

    logic                          en;
    logic                          accept;

    logic signed [DATA_WIDTH-1:0]  data_s;
    logic signed [COEF_WIDTH-1:0]  coef_s;
    logic signed [PROD_WIDTH-1:0]  prod_d;

    logic [TAP_WIDTH-1:0]          tap_cnt_q, tap_cnt_d;

    logic                          s1_valid_q;
    logic signed [PROD_WIDTH-1:0]  s1_prod_q;
    logic [TAP_WIDTH-1:0]          s1_idx_q;
    logic [PHASE_WIDTH-1:0]        s1_phase_q;
    logic                          s1_last_q;

    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic                          add_ovf;
    logic                          s2_go;
    logic                          s2_first;
    logic                          s2_last;

    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [PHASE_WIDTH-1:0]        phase_q, phase_d;
    logic                          ovf_q, ovf_d;

    logic                          out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]          out_acc_q, out_acc_d;
    logic [PHASE_WIDTH-1:0]        out_phase_q, out_phase_d;
    logic                          out_ovf_q, out_ovf_d;
    logic                          tap_err_q, tap_err_d;

    // A held output blocks everything upstream, so the whole pipe shares one enable.
    assign en        = !(out_valid_q && !ready_in);
    assign ready_out = en;
    assign accept    = valid_in && en;

    assign data_s = $signed(data_in);
    assign coef_s = $signed(coef_in);
    assign prod_d = PROD_WIDTH'(data_s) * PROD_WIDTH'(coef_s);

    always_comb begin
        tap_cnt_d = tap_cnt_q;
        if (accept) begin
            tap_cnt_d = (tap_cnt_q == LAST_TAP) ? '0 : tap_cnt_q + TAP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            tap_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_idx_q   <= '0;
            s1_phase_q <= '0;
            s1_last_q  <= 1'b0;
        end else begin
            tap_cnt_q <= tap_cnt_d;
            if (en) begin
                s1_valid_q <= valid_in;
                if (valid_in) begin
                    s1_prod_q  <= prod_d;
                    s1_idx_q   <= tap_cnt_q;
                    s1_phase_q <= phase_in;
                    s1_last_q  <= last_in;
                end
            end
        end
    end

    assign prod_ext = ACC_WIDTH'(s1_prod_q);
    assign sum      = acc_q + prod_ext;
    assign add_ovf  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    assign s2_go    = en && s1_valid_q;
    assign s2_first = (s1_idx_q == '0);
    assign s2_last  = (s1_idx_q == LAST_TAP);

    always_comb begin
        acc_d       = acc_q;
        phase_d     = phase_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_phase_d = out_phase_q;
        out_ovf_d   = out_ovf_q;
        tap_err_d   = 1'b0;

        if (s2_go) begin
            if (s2_first) begin
                acc_d   = prod_ext;
                phase_d = s1_phase_q;
                ovf_d   = 1'b0;
            end else begin
                acc_d = sum;
                ovf_d = ovf_q || add_ovf;
            end
            // The tap count decides completion; the source marker is only cross-checked.
            tap_err_d = (s1_last_q != s2_last);
        end

        if (s2_go && s2_last) begin
            out_valid_d = 1'b1;
            out_acc_d   = acc_d;
            out_phase_d = phase_d;
            out_ovf_d   = ovf_d;
        end else if (out_valid_q && ready_in) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            acc_q       <= '0;
            phase_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_phase_q <= '0;
            out_ovf_q   <= 1'b0;
            tap_err_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_phase_q <= out_phase_d;
            out_ovf_q   <= out_ovf_d;
            tap_err_q   <= tap_err_d;
        end
    end

    assign valid_out = out_valid_q;
    assign acc_out   = out_acc_q;
    assign phase_out = out_phase_q;
    assign ovf_out   = out_ovf_q;
    assign tap_err   = tap_err_q;

endmodule

// File: tb/tb_pfb_tap_mac.sv
// tb/tb_pfb_tap_mac.sv - directed bench for pfb_tap_mac
module tb_pfb_tap_mac;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic        valid_in;
    logic [15:0] data_in;
    logic [24:0] coef_in;
    logic [5:0]  phase_in;
    logic        last_in;
    logic        ready_in;

    logic        ready_out, valid_out, ovf_out, tap_err;
    logic [47:0] acc_out;
    logic [5:0]  phase_out;

    logic        ready_out42, valid_out42, ovf_out42, tap_err42;
    logic [41:0] acc_out42;
    logic [5:0]  phase_out42;

    always #5 clk = ~clk;

    pfb_tap_mac dut (
        .clk(clk), .sync_reset(sync_reset), .valid_in(valid_in), .data_in(data_in),
        .coef_in(coef_in), .phase_in(phase_in), .last_in(last_in), .ready_out(ready_out),
        .valid_out(valid_out), .ready_in(ready_in), .acc_out(acc_out),
        .phase_out(phase_out), .ovf_out(ovf_out), .tap_err(tap_err)
    );

    pfb_tap_mac #(.ACC_WIDTH(42)) dut42 (
        .clk(clk), .sync_reset(sync_reset), .valid_in(valid_in), .data_in(data_in),
        .coef_in(coef_in), .phase_in(phase_in), .last_in(last_in), .ready_out(ready_out42),
        .valid_out(valid_out42), .ready_in(ready_in), .acc_out(acc_out42),
        .phase_out(phase_out42), .ovf_out(ovf_out42), .tap_err(tap_err42)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    longint q_acc[$];
    int     q_phase[$];
    int     q_ovf[$];
    int     q_cyc[$];
    int     cyc = 0;
    int     err_pulses = 0;

    always @(negedge clk) begin
        cyc++;
        if (!sync_reset && valid_out && ready_in) begin
            q_acc.push_back(longint'($signed(acc_out)));
            q_phase.push_back(int'(phase_out));
            q_ovf.push_back(int'(ovf_out));
            q_cyc.push_back(cyc);
        end
        if (tap_err) err_pulses++;
    end

    task automatic clear_mon();
        q_acc.delete();
        q_phase.delete();
        q_ovf.delete();
        q_cyc.delete();
        err_pulses = 0;
    endtask

    task automatic send(input longint d, input longint c, input int ph, input bit last);
        int guard;
        guard    = 0;
        valid_in = 1'b1;
        data_in  = 16'(d);
        coef_in  = 25'(c);
        phase_in = 6'(ph);
        last_in  = last;
        while (!ready_out && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!ready_out) check("send_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        last_in  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_phase(input longint d, input longint c, input int ph, input bit [7:0] last_mask);
        for (int j = 0; j < 8; j++) send(d, c, ph, last_mask[j]);
    endtask

    int drops;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        sync_reset = 1'b1;
        valid_in   = 1'b0;
        data_in    = '0;
        coef_in    = '0;
        phase_in   = '0;
        last_in    = 1'b0;
        ready_in   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_acc", acc_out, 0);
        check("rst_phase", phase_out, 0);
        check("rst_ovf", ovf_out, 0);
        check("rst_err", tap_err, 0);
        sync_reset = 1'b0;
        idle(1);

        // basic sum with exact latency
        clear_mon();
        send_phase(1000, 2000, 5, 8'b1000_0000);
        check("basic_lat1", valid_out, 0);
        valid_in = 1'b0;
        @(posedge clk); #1;
        check("basic_lat2", valid_out, 1);
        check("basic_acc", longint'($signed(acc_out)), 16000000);
        check("basic_phase", phase_out, 5);
        check("basic_ovf", ovf_out, 0);
        idle(3);
        check("basic_count", q_acc.size(), 1);
        check("basic_err", err_pulses, 0);

        // extreme negatives; 42-bit instance wraps 2^42 to 0 with overflow
        clear_mon();
        send_phase(-32768, -16777216, 30, 8'b1000_0000);
        idle(1);
        check("ext_valid", valid_out, 1);
        check("ext_acc48", longint'($signed(acc_out)), 64'sd4398046511104);
        check("ext_ovf48", ovf_out, 0);
        check("ext_acc42", longint'($signed(acc_out42)), 0);
        check("ext_ovf42", ovf_out42, 1);
        idle(3);

        // continuous stream of four phases
        clear_mon();
        drops = 0;
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 8; j++) begin
                if (!ready_out) drops++;
                send(p * 10 + j, 1, p, j == 7);
            end
        end
        idle(4);
        check("cont_drops", drops, 0);
        check("cont_count", q_acc.size(), 4);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("cont_acc%0d", p), q_acc[p], 80 * p + 28);
            check($sformatf("cont_phase%0d", p), q_phase[p], p);
            if (p > 0) check($sformatf("cont_gap%0d", p), q_cyc[p] - q_cyc[p-1], 8);
        end

        // backpressure holds the completed sum and stalls the next phase
        clear_mon();
        ready_in = 1'b0;
        send_phase(3, -7, 9, 8'b1000_0000);
        send(2, 5, 10, 1'b0);
        valid_in = 1'b1;
        data_in  = 16'd2;
        coef_in  = 25'd5;
        phase_in = 6'd10;
        last_in  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_ready%0d", k), ready_out, 0);
            check($sformatf("bp_valid%0d", k), valid_out, 1);
            check($sformatf("bp_acc%0d", k), longint'($signed(acc_out)), -168);
            @(posedge clk); #1;
        end
        ready_in = 1'b1;
        #1;
        for (int j = 1; j < 8; j++) send(2, 5, 10, j == 7);
        idle(4);
        check("bp_count", q_acc.size(), 2);
        check("bp_acc_a", q_acc[0], -168);
        check("bp_phase_a", q_phase[0], 9);
        check("bp_acc_b", q_acc[1], 80);
        check("bp_phase_b", q_phase[1], 10);
        check("bp_err", err_pulses, 0);

        // stray end marker on tap 5
        clear_mon();
        send_phase(-5, 11, 12, 8'b1010_0000);
        idle(4);
        check("mk_err", err_pulses, 1);
        check("mk_count", q_acc.size(), 1);
        check("mk_acc", q_acc[0], -440);
        check("mk_phase", q_phase[0], 12);

        // reset in the middle of a sum
        clear_mon();
        for (int j = 0; j < 4; j++) send(100, 100, 20, 1'b0);
        valid_in   = 1'b0;
        sync_reset = 1'b1;
        @(posedge clk); #1;
        sync_reset = 1'b0;
        check("rs_valid", valid_out, 0);
        send_phase(1, 1, 21, 8'b1000_0000);
        idle(4);
        check("rs_count", q_acc.size(), 1);
        check("rs_acc", q_acc[0], 8);
        check("rs_phase", q_phase[0], 21);
        check("rs_err", err_pulses, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
